// File: rtl/peri_bus_pkg.sv
// Shared types and constants for the peripheral bus arbiter.
// Contents: FSM state encoding (IDLE, BUSY, WAIT_CPL) and IDLE_N, the
// "no transfer" value of the active-low size/strobe fields.
package peri_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    WAIT_CPL = 2'd2
  } state_t;

  // write_n / read_n value meaning "no access"; 00/01/10 select 8/16/32 bit.
  localparam logic [1:0] IDLE_N = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational.
// Ports: req[1:0] (requests, bit N = master N), last (1 = master 1 owned the
//        bus most recently), gnt[1:0] (one-hot pick, 00 when no request).
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On a tie the master that did not own the bus last time wins.
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/peri_bus_arbiter.sv
// Two-master arbiter in front of a single peripheral bus (m0 = core, m1 = DMA/debug).
// Ports: clk/rst (sync, active high); mN_* master request/response pairs;
//        per_* peripheral bus side; grant (one-hot owner); err (sticky read
//        timeout flag) cleared by err_clr.
module peri_bus_arbiter
  import peri_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 16,
  parameter logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] m0_addr,
  input  logic [31:0] m0_data_in,
  input  logic [1:0]  m0_write_n,
  input  logic [1:0]  m0_read_n,
  output logic [31:0] m0_data_out,
  output logic        m0_data_ready,
  input  logic        m0_read_complete,
  input  logic [10:0] m1_addr,
  input  logic [31:0] m1_data_in,
  input  logic [1:0]  m1_write_n,
  input  logic [1:0]  m1_read_n,
  output logic [31:0] m1_data_out,
  output logic        m1_data_ready,
  input  logic        m1_read_complete,
  output logic [10:0] per_addr,
  output logic [31:0] per_data_in,
  output logic [1:0]  per_write_n,
  output logic [1:0]  per_read_n,
  input  logic [31:0] per_data_out,
  input  logic        per_data_ready,
  output logic        per_read_complete,
  output logic [1:0]  grant,
  output logic        err,
  input  logic        err_clr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t          state, state_nxt;
  logic [1:0]      gnt_q, gnt_nxt;
  logic            last_q, last_nxt;   // 1 = m1 was the last owner
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic            err_q;
  logic            timeout;

  logic [1:0]      req;
  logic [1:0]      pick;

  assign req[0] = (m0_write_n != IDLE_N) || (m0_read_n != IDLE_N);
  assign req[1] = (m1_write_n != IDLE_N) || (m1_read_n != IDLE_N);

  rr_arb2 u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (pick)
  );

  // Granted-master view; only meaningful while gnt_q is non-zero.
  logic        sel;
  logic [10:0] g_addr;
  logic [31:0] g_wdat;
  logic [1:0]  g_wr_n, g_rd_n;
  logic        g_cpl, g_is_wr, g_is_rd;

  assign sel     = gnt_q[1];
  assign g_addr  = sel ? m1_addr          : m0_addr;
  assign g_wdat  = sel ? m1_data_in       : m0_data_in;
  assign g_wr_n  = sel ? m1_write_n       : m0_write_n;
  assign g_rd_n  = sel ? m1_read_n        : m0_read_n;
  assign g_cpl   = sel ? m1_read_complete : m0_read_complete;
  // A write takes priority over a read presented in the same request.
  assign g_is_wr = (g_wr_n != IDLE_N);
  assign g_is_rd = !g_is_wr && (g_rd_n != IDLE_N);

  logic        rsp_rdy;
  logic [31:0] rsp_dat;

  always_comb begin
    state_nxt         = state;
    gnt_nxt           = gnt_q;
    last_nxt          = last_q;
    cnt_nxt           = cnt_q;
    timeout           = 1'b0;
    rsp_rdy           = 1'b0;
    rsp_dat           = '0;
    per_addr          = '0;
    per_data_in       = '0;
    per_write_n       = IDLE_N;
    per_read_n        = IDLE_N;
    per_read_complete = 1'b0;

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_nxt = BUSY;
          gnt_nxt   = pick;
          cnt_nxt   = '0;
        end
      end

      BUSY: begin
        per_addr    = g_addr;
        per_data_in = g_wdat;
        per_write_n = g_wr_n;
        per_read_n  = g_is_wr ? IDLE_N : g_rd_n;
        if (g_is_wr) begin
          rsp_rdy = per_data_ready;
          if (per_data_ready) begin
            state_nxt = IDLE;
            gnt_nxt   = 2'b00;
            last_nxt  = sel;
          end
        end else if (g_is_rd) begin
          if (per_data_ready) begin
            rsp_rdy   = 1'b1;
            rsp_dat   = per_data_out;
            state_nxt = WAIT_CPL;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            // Peripheral never answered: hand back filler data and flag it.
            rsp_rdy   = 1'b1;
            rsp_dat   = TIMEOUT_DATA;
            timeout   = 1'b1;
            state_nxt = WAIT_CPL;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end else begin
          // Master withdrew its request mid-transfer: drop it quietly.
          state_nxt = IDLE;
          gnt_nxt   = 2'b00;
        end
      end

      WAIT_CPL: begin
        // Strobes stay idle so the peripheral sees no second access.
        per_addr          = g_addr;
        per_data_in       = g_wdat;
        per_read_complete = g_cpl;
        if (g_cpl) begin
          state_nxt = IDLE;
          gnt_nxt   = 2'b00;
          last_nxt  = sel;
        end
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt_q  <= 2'b00;
      last_q <= 1'b1;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      gnt_q  <= gnt_nxt;
      last_q <= last_nxt;
      cnt_q  <= cnt_nxt;
      // Set beats clear when both happen in one cycle.
      err_q  <= timeout | (err_q & ~err_clr);
    end
  end

  assign m0_data_ready = rsp_rdy & ~sel;
  assign m1_data_ready = rsp_rdy &  sel;
  assign m0_data_out   = (rsp_rdy && !sel) ? rsp_dat : 32'd0;
  assign m1_data_out   = (rsp_rdy &&  sel) ? rsp_dat : 32'd0;
  assign grant         = gnt_q;
  assign err           = err_q;

endmodule

// File: tb/tb_peri_bus_arbiter.sv
// Self-checking bench for peri_bus_arbiter: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a transaction-level model.
module tb_peri_bus_arbiter;

  localparam int unsigned TO = 16;

  logic        clk, rst;
  logic [10:0] m0_addr, m1_addr;
  logic [31:0] m0_data_in, m1_data_in;
  logic [1:0]  m0_write_n, m0_read_n, m1_write_n, m1_read_n;
  logic [31:0] m0_data_out, m1_data_out;
  logic        m0_data_ready, m1_data_ready;
  logic        m0_read_complete, m1_read_complete;
  logic [10:0] per_addr;
  logic [31:0] per_data_in;
  logic [1:0]  per_write_n, per_read_n;
  logic [31:0] per_data_out;
  logic        per_data_ready, per_read_complete;
  logic [1:0]  grant;
  logic        err, err_clr;

  peri_bus_arbiter #(.TIMEOUT(TO), .TIMEOUT_DATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_data_in(m0_data_in), .m0_write_n(m0_write_n),
    .m0_read_n(m0_read_n), .m0_data_out(m0_data_out), .m0_data_ready(m0_data_ready),
    .m0_read_complete(m0_read_complete),
    .m1_addr(m1_addr), .m1_data_in(m1_data_in), .m1_write_n(m1_write_n),
    .m1_read_n(m1_read_n), .m1_data_out(m1_data_out), .m1_data_ready(m1_data_ready),
    .m1_read_complete(m1_read_complete),
    .per_addr(per_addr), .per_data_in(per_data_in), .per_write_n(per_write_n),
    .per_read_n(per_read_n), .per_data_out(per_data_out), .per_data_ready(per_data_ready),
    .per_read_complete(per_read_complete),
    .grant(grant), .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic [1:0] wn, input logic [1:0] rn,
                       input logic [10:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_write_n = wn; m0_read_n = rn; m0_addr = a; m0_data_in = d;
    end else begin
      m1_write_n = wn; m1_read_n = rn; m1_addr = a; m1_data_in = d;
    end
  endtask

  task automatic set_cpl(input int m, input logic v);
    if (m == 0) m0_read_complete = v;
    else        m1_read_complete = v;
  endtask

  function automatic logic rdy_of(input int m);
    return (m == 0) ? m0_data_ready : m1_data_ready;
  endfunction

  function automatic logic [31:0] dout_of(input int m);
    return (m == 0) ? m0_data_out : m1_data_out;
  endfunction

  typedef struct {
    int          m;
    logic [1:0]  wn, rn;
    logic [10:0] addr;
    logic [31:0] wdat, rdat;
    logic [1:0]  exp_grant, exp_pw, exp_pr;
  } vec_t;

  // Watchdog: the run must never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[6];
    vec_t        v;
    int          m, o, got, d, exp_k, c;
    logic        pend[2];
    logic [1:0]  wn[2], rn[2];
    logic [10:0] ad[2];
    logic [31:0] wd[2];
    logic [31:0] rd, exp_dat;
    logic        last_m, err_m, is_wr;

    vt[0] = '{0, 2'b11 - 2'b01, 2'b11, 11'h041, 32'h0000_00A5, 32'h0, 2'b01, 2'b10, 2'b11};
    vt[1] = '{1, 2'b00, 2'b11, 11'h7FF, 32'h0000_00FF, 32'h0, 2'b10, 2'b00, 2'b11};
    vt[2] = '{0, 2'b01, 2'b00, 11'h200, 32'hDEAD_BEEF, 32'h0, 2'b01, 2'b01, 2'b11};
    vt[3] = '{1, 2'b11, 2'b10, 11'h123, 32'h0, 32'h1234_5678, 2'b10, 2'b11, 2'b10};
    vt[4] = '{0, 2'b11, 2'b01, 11'h00F, 32'h0, 32'hCAFE_BABE, 2'b01, 2'b11, 2'b01};
    vt[5] = '{1, 2'b10, 2'b10, 11'h3C3, 32'h5555_AAAA, 32'h0, 2'b10, 2'b10, 2'b11};

    rst = 1'b1; err_clr = 1'b0;
    set_m(0, 2'b11, 2'b11, 11'h0, 32'h0);
    set_m(1, 2'b11, 2'b11, 11'h0, 32'h0);
    m0_read_complete = 1'b0; m1_read_complete = 1'b0;
    per_data_out = 32'h0; per_data_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_per_write_n", 32'(per_write_n), 32'h3);
    check("rst_per_read_n", 32'(per_read_n), 32'h3);
    check("rst_per_addr", 32'(per_addr), 32'h0);
    check("rst_per_read_complete", 32'(per_read_complete), 32'h0);

    // ---------------- vector table: isolated single-master transfers
    for (int i = 0; i < 6; i++) begin
      v = vt[i];
      m = v.m;
      set_m(m, v.wn, v.rn, v.addr, v.wdat);
      #1;
      check($sformatf("v%0d_no_same_cycle_grant", i), 32'(grant), 32'h0);
      tick(); #1;
      check($sformatf("v%0d_grant", i), 32'(grant), 32'(v.exp_grant));
      check($sformatf("v%0d_per_addr", i), 32'(per_addr), 32'(v.addr));
      check($sformatf("v%0d_per_data_in", i), per_data_in, v.wdat);
      check($sformatf("v%0d_per_write_n", i), 32'(per_write_n), 32'(v.exp_pw));
      check($sformatf("v%0d_per_read_n", i), 32'(per_read_n), 32'(v.exp_pr));
      check($sformatf("v%0d_rdy_before", i), 32'(rdy_of(m)), 32'h0);
      per_data_ready = 1'b1; per_data_out = v.rdat;
      #1;
      check($sformatf("v%0d_rdy", i), 32'(rdy_of(m)), 32'h1);
      check($sformatf("v%0d_other_rdy", i), 32'(rdy_of(1 - m)), 32'h0);
      check($sformatf("v%0d_other_dout", i), dout_of(1 - m), 32'h0);
      if (v.exp_pr != 2'b11) check($sformatf("v%0d_dout", i), dout_of(m), v.rdat);
      tick();
      per_data_ready = 1'b0; per_data_out = 32'h0;
      set_m(m, 2'b11, 2'b11, 11'h0, 32'h0);
      if (v.exp_pr != 2'b11) begin
        #1;
        check($sformatf("v%0d_wait_cpl_grant", i), 32'(grant), 32'(v.exp_grant));
        check($sformatf("v%0d_wait_cpl_read_n", i), 32'(per_read_n), 32'h3);
        set_cpl(m, 1'b1);
        #1;
        check($sformatf("v%0d_read_complete", i), 32'(per_read_complete), 32'h1);
        tick();
        set_cpl(m, 1'b0);
      end
      #2;
      check($sformatf("v%0d_idle_grant", i), 32'(grant), 32'h0);
      check($sformatf("v%0d_idle_write_n", i), 32'(per_write_n), 32'h3);
    end

    // ---------------- request dropped while granted: back to IDLE, no error
    set_m(0, 2'b10, 2'b11, 11'h011, 32'h1);
    tick(); #1;
    check("drop_grant", 32'(grant), 32'h1);
    set_m(0, 2'b11, 2'b11, 11'h0, 32'h0);
    tick(); #1;
    check("drop_idle_grant", 32'(grant), 32'h0);
    check("drop_no_err", 32'(err), 32'h0);

    // ---------------- simultaneous reads after reset: m0 first, then m1
    rst = 1'b1; tick(); rst = 1'b0;
    set_m(0, 2'b11, 2'b10, 11'h010, 32'h0);
    set_m(1, 2'b11, 2'b10, 11'h020, 32'h0);
    tick(); #1;
    check("tie_first_grant", 32'(grant), 32'h1);
    check("tie_first_addr", 32'(per_addr), 32'h010);
    per_data_ready = 1'b1; per_data_out = 32'h0000_AAAA; #1;
    check("tie_m0_rdy", 32'(m0_data_ready), 32'h1);
    check("tie_m1_not_rdy", 32'(m1_data_ready), 32'h0);
    tick();
    per_data_ready = 1'b0;
    set_m(0, 2'b11, 2'b11, 11'h0, 32'h0);
    set_cpl(0, 1'b1);
    tick(); set_cpl(0, 1'b0); #1;
    check("tie_idle_between", 32'(grant), 32'h0);
    tick(); #1;
    check("tie_second_grant", 32'(grant), 32'h2);
    check("tie_second_addr", 32'(per_addr), 32'h020);
    per_data_ready = 1'b1; per_data_out = 32'h0000_BBBB; #1;
    check("tie_m1_dout", m1_data_out, 32'h0000_BBBB);
    tick();
    per_data_ready = 1'b0;
    set_m(1, 2'b11, 2'b11, 11'h0, 32'h0);
    set_cpl(1, 1'b1);
    tick(); set_cpl(1, 1'b0);

    // ---------------- m1 read, peripheral answers after 3 wait cycles
    set_m(1, 2'b11, 2'b10, 11'h055, 32'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("slow_wait%0d_rdy", k), 32'(m1_data_ready), 32'h0);
      tick();
    end
    per_data_ready = 1'b1; per_data_out = 32'h1234_5678; #1;
    check("slow_rdy", 32'(m1_data_ready), 32'h1);
    check("slow_dout", m1_data_out, 32'h1234_5678);
    tick();
    per_data_ready = 1'b0;
    set_m(1, 2'b11, 2'b11, 11'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("slow_hold%0d_grant", k), 32'(grant), 32'h2);
      tick();
    end
    set_cpl(1, 1'b1); #1;
    check("slow_read_complete", 32'(per_read_complete), 32'h1);
    tick(); set_cpl(1, 1'b0); #1;
    check("slow_idle", 32'(grant), 32'h0);

    // ---------------- m0 read timeout, then err_clr
    set_m(0, 2'b11, 2'b10, 11'h066, 32'h0);
    tick();
    got = -1;
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (m0_data_ready) begin got = k; break; end
      tick();
    end
    check("timeout_cycle", 32'(got), 32'(TO));
    check("timeout_dout", m0_data_out, 32'hFFFF_FFFF);
    tick();
    set_m(0, 2'b11, 2'b11, 11'h0, 32'h0); #1;
    check("timeout_err_set", 32'(err), 32'h1);
    set_cpl(0, 1'b1);
    tick(); set_cpl(0, 1'b0); #1;
    check("timeout_err_sticky", 32'(err), 32'h1);
    err_clr = 1'b1;
    tick(); err_clr = 1'b0; #1;
    check("err_cleared", 32'(err), 32'h0);

    // ---------------- timeout with err_clr high: set wins; then reset in WAIT_CPL
    set_m(1, 2'b11, 2'b10, 11'h077, 32'h0);
    err_clr = 1'b1;
    tick();
    got = -1;
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (m1_data_ready) begin got = k; break; end
      tick();
    end
    check("setwins_timeout_cycle", 32'(got), 32'(TO));
    tick();
    err_clr = 1'b0;
    set_m(1, 2'b11, 2'b11, 11'h0, 32'h0); #1;
    check("setwins_err", 32'(err), 32'h1);
    check("setwins_wait_cpl_grant", 32'(grant), 32'h2);
    set_cpl(1, 1'b1);
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    check("rst_wait_cpl_grant", 32'(grant), 32'h0);
    check("rst_wait_cpl_read_complete", 32'(per_read_complete), 32'h0);
    check("rst_wait_cpl_err", 32'(err), 32'h0);
    set_cpl(1, 1'b0);
    tick();

    // ---------------- randomized traffic vs transaction-level model
    rst = 1'b1; tick(); rst = 1'b0;
    last_m = 1'b1; err_m = 1'b0;
    for (int j = 0; j < 2; j++) begin
      pend[j] = 1'b1;
      do begin wn[j] = 2'($urandom_range(0, 3)); rn[j] = 2'($urandom_range(0, 3)); end
      while (wn[j] == 2'b11 && rn[j] == 2'b11);
      ad[j] = 11'($urandom); wd[j] = $urandom;
    end
    for (int t = 0; t < 40; t++) begin
      for (int j = 0; j < 2; j++) begin
        if (pend[j]) set_m(j, wn[j], rn[j], ad[j], wd[j]);
        else         set_m(j, 2'b11, 2'b11, 11'h0, 32'h0);
      end
      if (pend[0] && pend[1]) o = last_m ? 0 : 1;
      else                    o = pend[0] ? 0 : 1;
      is_wr = (wn[o] != 2'b11);
      tick(); #1;
      check($sformatf("rnd%0d_grant", t), 32'(grant), (o == 0) ? 32'h1 : 32'h2);
      check($sformatf("rnd%0d_per_write_n", t), 32'(per_write_n), is_wr ? 32'(wn[o]) : 32'h3);
      check($sformatf("rnd%0d_per_read_n", t), 32'(per_read_n), is_wr ? 32'h3 : 32'(rn[o]));
      check($sformatf("rnd%0d_per_addr", t), 32'(per_addr), 32'(ad[o]));
      rd = $urandom;
      if (is_wr) begin
        d = $urandom_range(0, 5); exp_k = d; exp_dat = 32'h0;
      end else begin
        d = $urandom_range(0, 20);
        exp_k   = (d < int'(TO)) ? d : int'(TO) - 1;
        exp_dat = (d < int'(TO)) ? rd : 32'hFFFF_FFFF;
        if (d >= int'(TO)) err_m = 1'b1;
      end
      got = -1;
      for (int k = 0; k < 40; k++) begin
        per_data_ready = (k == d); per_data_out = rd;
        #1;
        if (rdy_of(o)) begin got = k; break; end
        tick();
      end
      check($sformatf("rnd%0d_ready_cycle", t), 32'(got), 32'(exp_k));
      check($sformatf("rnd%0d_other_rdy", t), 32'(rdy_of(1 - o)), 32'h0);
      if (!is_wr) check($sformatf("rnd%0d_dout", t), dout_of(o), exp_dat);
      tick();
      per_data_ready = 1'b0;
      set_m(o, 2'b11, 2'b11, 11'h0, 32'h0);
      if (!is_wr) begin
        c = $urandom_range(0, 2);
        for (int k = 0; k < c; k++) tick();
        set_cpl(o, 1'b1); #1;
        check($sformatf("rnd%0d_read_complete", t), 32'(per_read_complete), 32'h1);
        tick();
        set_cpl(o, 1'b0);
      end
      #1;
      check($sformatf("rnd%0d_idle", t), 32'(grant), 32'h0);
      check($sformatf("rnd%0d_err", t), 32'(err), 32'(err_m));
      // Model update: served master may re-arm with a fresh op; the other
      // keeps its held request or re-arms if it was idle.
      last_m = (o == 1);
      pend[o] = (t < 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (!pend[1 - o]) begin
        pend[1 - o] = 1'b1;
        do begin wn[1-o] = 2'($urandom_range(0, 3)); rn[1-o] = 2'($urandom_range(0, 3)); end
        while (wn[1-o] == 2'b11 && rn[1-o] == 2'b11);
        ad[1-o] = 11'($urandom); wd[1-o] = $urandom;
      end
      if (pend[o]) begin
        do begin wn[o] = 2'($urandom_range(0, 3)); rn[o] = 2'($urandom_range(0, 3)); end
        while (wn[o] == 2'b11 && rn[o] == 2'b11);
        ad[o] = 11'($urandom); wd[o] = $urandom;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/peri_bus_arbiter.md
PERI_BUS_ARBITER -- requirements
Module: peri_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, max cycles a granted read waits for per_data_ready.
REQ-002 Parameter TIMEOUT_DATA, default 32'hFFFF_FFFF, read data returned on timeout.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 mN_addr  in  11  master N address, N in {0,1}; m0 = TinyQV core, m1 = DMA/debug.
REQ-006 mN_data_in  in  32  master N write data.
REQ-007 mN_write_n / mN_read_n  in  2 each  11 = idle, 00/01/10 = 8/16/32-bit.
REQ-008 mN_data_out  out  32 / mN_data_ready  out  1 / mN_read_complete  in  1  master N response side.
REQ-009 per_addr  out  11 / per_data_in  out  32 / per_write_n, per_read_n  out  2  to peripheral bus.
REQ-010 per_data_out  in  32 / per_data_ready  in  1 / per_read_complete  out  1  from/to peripheral bus.
REQ-011 grant  out  2  one-hot current owner (00 = none); err  out  1  sticky timeout flag; err_clr  in  1  clears err.

Function
REQ-012 Master N requests when mN_write_n != 11 or mN_read_n != 11; requests held until mN_data_ready.
REQ-013 FSM states IDLE, BUSY, WAIT_CPL; reset state IDLE.
REQ-014 IDLE: per_write_n = per_read_n = 11, per_addr = 0, per_data_in = 0, grant = 00.
REQ-015 IDLE with one request -> BUSY next cycle, grant that master; two requests -> grant master not in last_grant (round-robin).
REQ-016 BUSY: per_* driven from granted master combinationally; non-granted master sees mN_data_ready = 0, mN_data_out = 0.
REQ-017 BUSY write: granted mN_data_ready = per_data_ready; on ready -> IDLE next cycle, last_grant updated.
REQ-018 BUSY read: on per_data_ready, mN_data_ready = 1 and mN_data_out = per_data_out same cycle; -> WAIT_CPL.
REQ-019 WAIT_CPL: per_read_n forced 11, per_read_complete = granted mN_read_complete; on it -> IDLE, last_grant updated.
REQ-020 Read timeout counter clears on BUSY entry, increments each BUSY read cycle without per_data_ready; at count == TIMEOUT-1 with no ready: mN_data_ready = 1, mN_data_out = TIMEOUT_DATA, err set, -> WAIT_CPL.
REQ-021 Write and read requested simultaneously by one master: write served, read ignored for that transaction.
REQ-022 No request ever granted in the same cycle it first appears (one-cycle registered arbitration latency).
REQ-023 err_clr and timeout in same cycle: err = 1 (set wins).
REQ-024 Master dropping request while granted in BUSY (illegal): return to IDLE next cycle, no error.

Reset
REQ-025 rst: state IDLE, grant 00, err 0, counter 0, last_grant = m1 so m0 wins first tie.
REQ-026 rst mid-transaction aborts it; all outputs take IDLE values the cycle after rst sampled high.

Structure
REQ-027 State encoding and IDLE_N (2'b11) constant in shared package peri_bus_pkg.
REQ-028 Single module; optional sub-module rr_arb2 for the two-way round-robin pick.

Verification
REQ-029 m0 32-bit write addr 0x041 data 0xA5 alone -> grant 01 cycle+1, per_write_n 10, m0_data_ready 1, IDLE next.
REQ-030 m0 and m1 reads same cycle after reset -> m0 served first, then m1; grant 01 then 10.
REQ-031 m1 read, per_data_ready after 3 cycles with 0x1234_5678 -> m1_data_out 0x1234_5678; IDLE only after m1_read_complete.
REQ-032 m0 read, per_data_ready never -> after 16 BUSY cycles m0_data_out 0xFFFF_FFFF, err 1; err_clr -> err 0.
REQ-033 rst asserted during WAIT_CPL -> next cycle grant 00, per_read_complete 0, err 0.
REQ-034 Back-to-back requests from both masters for 8 transactions -> strict alternation, no starvation.
